// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//   Two-stage elastic immediate generator between fetch and decode/execute.
//   The format is decoded from the raw opcode (no imm_src from control). The
//   immediate is extended to XLEN and the PC-relative target (branch, JAL,
//   AUIPC) is precomputed in the second stage.
//
// Parameters
//   XLEN         datapath width, 32 or 64 (shamt is 5 bits at 32, 6 at 64)
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset; clears valids and all data
//   flush        drop every in-flight entry and any input accepted this cycle
//   in_valid     upstream offers in_instr/in_pc
//   in_ready     stage accepts this cycle (combinational from state, out_ready)
//   in_instr     raw 32-bit instruction
//   in_pc        PC of in_instr
//   out_valid    output entry valid
//   out_ready    downstream accepts
//   out_imm      extended immediate
//   out_fmt      000 I, 001 B, 010 S, 011 SHAMT, 100 U, 101 J, 110 ZIMM, 111 NONE
//   out_target   pc+imm for B, J and AUIPC, else 0 (wraps modulo 2^XLEN)
//   out_pc       PC carried through
//   out_illegal  unrecognised opcode (includes instr[1:0] != 2'b11)
module imm_gen_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_B     = 3'b001,
    FMT_S     = 3'b010,
    FMT_SHAMT = 3'b011,
    FMT_U     = 3'b100,
    FMT_J     = 3'b101,
    FMT_ZIMM  = 3'b110,
    FMT_NONE  = 3'b111
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic WIDE_SHAMT = (XLEN == 64);

  // ---------------------------------------------------------------------------
  // Decode (combinational, on the incoming instruction)
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  fmt_e            d_fmt;
  logic            d_illegal;
  logic            d_pcrel;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  always_comb begin
    d_fmt     = FMT_NONE;
    d_illegal = 1'b0;
    d_pcrel   = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: d_fmt = FMT_I;
      OP_IMM:           d_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
      OP_STORE:         d_fmt = FMT_S;
      OP_BRANCH: begin
        d_fmt   = FMT_B;
        d_pcrel = 1'b1;
      end
      OP_JAL: begin
        d_fmt   = FMT_J;
        d_pcrel = 1'b1;
      end
      OP_LUI:           d_fmt = FMT_U;
      OP_AUIPC: begin
        d_fmt   = FMT_U;
        d_pcrel = 1'b1;
      end
      OP_SYSTEM:        d_fmt = funct3[2] ? FMT_ZIMM : FMT_NONE;
      OP_REG, OP_FENCE: d_fmt = FMT_NONE;
      default: begin
        d_fmt     = FMT_NONE;
        d_illegal = 1'b1;
      end
    endcase
  end

  // Every format is first built as a 32-bit value. Zero-extended forms
  // (SHAMT, ZIMM) always have bit 31 clear, so a uniform sign extension of
  // bit 31 to XLEN is correct for all of them.
  always_comb begin
    imm32 = '0;
    case (d_fmt)
      FMT_I:     imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:     imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:     imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
      FMT_U:     imm32 = {in_instr[31:12], 12'b0};
      FMT_J:     imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
      FMT_SHAMT: imm32 = {26'b0, WIDE_SHAMT & in_instr[25], in_instr[24:20]};
      FMT_ZIMM:  imm32 = {27'b0, in_instr[19:15]};
      default:   imm32 = '0;
    endcase
  end

  if (XLEN == 64) begin : g_x64
    assign imm_x = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign imm_x = imm32;
  end

  // ---------------------------------------------------------------------------
  // Elastic pipeline: S1 holds the decoded fields, S2 the output register
  // ---------------------------------------------------------------------------
  logic            s1_valid, s2_valid;
  logic [XLEN-1:0] s1_pc, s1_imm;
  fmt_e            s1_fmt;
  logic            s1_illegal, s1_pcrel;
  logic [XLEN-1:0] s2_pc, s2_imm, s2_target;
  fmt_e            s2_fmt;
  logic            s2_illegal;

  logic s2_advance;
  logic accept;

  // S1 moves into S2 under the same condition that lets S2 drain, so a
  // bubble in S2 is always filled regardless of out_ready.
  assign s2_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_pc      <= '0;
      s1_imm     <= '0;
      s1_fmt     <= FMT_I;
      s1_illegal <= 1'b0;
      s1_pcrel   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_pc      <= in_pc;
        s1_imm     <= imm_x;
        s1_fmt     <= d_fmt;
        s1_illegal <= d_illegal;
        s1_pcrel   <= d_pcrel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      s2_pc      <= '0;
      s2_imm     <= '0;
      s2_fmt     <= FMT_I;
      s2_illegal <= 1'b0;
      s2_target  <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pc      <= s1_pc;
        s2_imm     <= s1_imm;
        s2_fmt     <= s1_fmt;
        s2_illegal <= s1_illegal;
        s2_target  <= s1_pcrel ? (s1_pc + s1_imm) : '0;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_pc      = s2_pc;
  assign out_imm     = s2_imm;
  assign out_fmt     = s2_fmt;
  assign out_illegal = s2_illegal;
  assign out_target  = s2_target;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc32 = '0;
  logic [63:0] in_pc64 = '0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_target32, out_pc32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_target64, out_pc64;
  logic [2:0]  out_fmt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_target(out_target32),
    .out_pc(out_pc32), .out_illegal(out_illegal32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_target(out_target64),
    .out_pc(out_pc64), .out_illegal(out_illegal64)
  );

  // Reference entry: what should emerge for one accepted instruction.
  typedef struct {
    logic [31:0] imm32, tgt32, pc32;
    logic [63:0] imm64, tgt64, pc64;
    logic [2:0]  fmt;
    logic        ill;
    bit          in_s2;
  } ent_t;

  ent_t q[$];

  function automatic ent_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [63:0] pc64);
    ent_t e;
    longint v, vsh64;
    bit pcrel, shamt;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    v = 0; vsh64 = 0; pcrel = 0; shamt = 0;
    e.fmt = 3'b111;
    e.ill = 1'b0;
    e.in_s2 = 1'b0;
    case (op)
      7'h03, 7'h67: begin e.fmt = 3'b000; v = longint'($signed(ins[31:20])); end
      7'h13:
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = 3'b011; shamt = 1;
          v = longint'(ins[24:20]);
          vsh64 = longint'(ins[25:20]);
        end else begin
          e.fmt = 3'b000; v = longint'($signed(ins[31:20]));
        end
      7'h23: begin e.fmt = 3'b010; v = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin
        e.fmt = 3'b001; pcrel = 1;
        v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h6F: begin
        e.fmt = 3'b101; pcrel = 1;
        v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h37, 7'h17: begin
        e.fmt = 3'b100; pcrel = (op == 7'h17);
        v = longint'($signed(ins[31:12])) * 4096;
      end
      7'h73: if (f3[2]) begin e.fmt = 3'b110; v = longint'(ins[19:15]); end
      7'h33, 7'h0F: e.fmt = 3'b111;
      default: e.ill = 1'b1;
    endcase
    e.imm32 = v[31:0];
    e.imm64 = shamt ? vsh64 : v;
    e.pc32  = pc;
    e.pc64  = pc64;
    e.tgt32 = pcrel ? pc + e.imm32 : 32'h0;
    e.tgt64 = pcrel ? pc64 + e.imm64 : 64'h0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check just before the rising edge,
  // then advance the reference queue at the rising edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [63:0] pc64, input logic ordy, input logic fl,
                       input logic rst);
    logic exp_rdy, exp_val, acc;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc32 = pc; in_pc64 = pc64;
    out_ready = ordy; flush = fl; reset = rst;
    #1;
    exp_rdy = !(q.size() == 2 && !ordy);
    exp_val = (q.size() > 0) && q[0].in_s2;
    if (!rst) begin
      chk("in_ready32", 64'(in_ready32), 64'(exp_rdy));
      chk("in_ready64", 64'(in_ready64), 64'(exp_rdy));
      chk("out_valid32", 64'(out_valid32), 64'(exp_val));
      chk("out_valid64", 64'(out_valid64), 64'(exp_val));
      if (exp_val) begin
        chk("imm32", 64'(out_imm32), 64'(q[0].imm32));
        chk("tgt32", 64'(out_target32), 64'(q[0].tgt32));
        chk("pc32", 64'(out_pc32), 64'(q[0].pc32));
        chk("fmt32", 64'(out_fmt32), 64'(q[0].fmt));
        chk("ill32", 64'(out_illegal32), 64'(q[0].ill));
        chk("imm64", out_imm64, q[0].imm64);
        chk("tgt64", out_target64, q[0].tgt64);
        chk("pc64", out_pc64, q[0].pc64);
        chk("fmt64", 64'(out_fmt64), 64'(q[0].fmt));
        chk("ill64", 64'(out_illegal64), 64'(q[0].ill));
      end
    end
    acc = v && exp_rdy && !fl && !rst;
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].in_s2 && ordy) void'(q.pop_front());
      if (q.size() > 0 && !q[0].in_s2) q[0].in_s2 = 1'b1;
      if (acc) q.push_back(model(ins, pc, pc64));
    end
  endtask

  // Direct look at the outputs just after a rising edge against literal values.
  task automatic peek32(input string tag, input logic val, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic [31:0] tgt);
    #1;
    chk({tag, "_valid"}, 64'(out_valid32), 64'(val));
    chk({tag, "_imm"}, 64'(out_imm32), 64'(imm));
    chk({tag, "_fmt"}, 64'(out_fmt32), 64'(fmt));
    chk({tag, "_tgt"}, 64'(out_target32), 64'(tgt));
  endtask

  task automatic peek64(input string tag, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic [63:0] tgt);
    #1;
    chk({tag, "_valid"}, 64'(out_valid64), 64'd1);
    chk({tag, "_imm"}, out_imm64, imm);
    chk({tag, "_fmt"}, 64'(out_fmt64), 64'(fmt));
    chk({tag, "_tgt"}, out_target64, tgt);
  endtask

  task automatic single(input logic [31:0] ins, input logic [31:0] pc);
    cycle(1'b1, ins, pc, {32'h0, pc}, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    #1;
    chk({tag, "_valid"}, 64'(out_valid32), 64'd0);
    chk({tag, "_imm"}, 64'(out_imm32), 64'd0);
    chk({tag, "_fmt"}, 64'(out_fmt32), 64'd0);
    chk({tag, "_tgt"}, 64'(out_target32), 64'd0);
    chk({tag, "_pc"}, 64'(out_pc32), 64'd0);
    chk({tag, "_ill"}, 64'(out_illegal32), 64'd0);
    chk({tag, "_valid64"}, 64'(out_valid64), 64'd0);
    chk({tag, "_imm64"}, out_imm64, 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready32), 64'd1);
  endtask

  logic [6:0] ops [12] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h6F,
                           7'h37, 7'h17, 7'h73, 7'h33, 7'h0F, 7'h5B};

  initial begin
    logic [31:0] r, ins;
    int unsigned idx;
    logic v, ordy, fl;

    // Reset
    cycle(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    chk_reset_state("reset");

    // Directed formats, two edges of latency each
    single(32'hFFF00093, 32'h0);    peek32("addi", 1'b1, 32'hFFFFFFFF, 3'b000, 32'h0);
    single(32'hFE000EE3, 32'h100);  peek32("beq", 1'b1, 32'hFFFFFFFC, 3'b001, 32'h000000FC);
    single(32'h008000EF, 32'h200);  peek32("jal", 1'b1, 32'h8, 3'b101, 32'h208);
    single(32'h123452B7, 32'h300);  peek32("lui", 1'b1, 32'h12345000, 3'b100, 32'h0);
    single(32'h4030D093, 32'h400);  peek64("srai64", 64'h3, 3'b011, 64'h0);
    single(32'h80000017, 32'h1000); peek64("auipc64", 64'hFFFFFFFF80000000, 3'b100, 64'hFFFFFFFF80001000);
    single(32'h3401D073, 32'h500);  peek64("csrrwi64", 64'h3, 3'b110, 64'h0);
    single(32'h00000000, 32'h600);  peek32("zero", 1'b1, 32'h0, 3'b111, 32'h0);
    chk("zero_ill", 64'(out_illegal32), 64'd1);

    // Backpressure: third back-to-back offer stalls, then all three drain in order
    cycle(1'b1, 32'h00100093, 32'h700, 64'h700, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h704, 64'h704, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h708, 64'h708, 1'b0, 1'b0, 1'b0);
    #1 chk("bp_in_ready", 64'(in_ready32), 64'd0);
    cycle(1'b1, 32'h00300193, 32'h708, 64'h708, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h708, 64'h708, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Flush with both stages full and an input accepted in the same cycle
    cycle(1'b1, 32'h00400213, 32'h800, 64'h800, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500293, 32'h804, 64'h804, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600313, 32'h808, 64'h808, 1'b1, 1'b1, 1'b0);
    #1 chk("flush_valid", 64'(out_valid32), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    single(32'h00700393, 32'h900);  peek32("post_flush", 1'b1, 32'h7, 3'b000, 32'h0);

    // Reset in the middle of backpressure
    cycle(1'b1, 32'hFFF00093, 32'hA00, 64'hA00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 32'hA04, 64'hA04, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h123452B7, 32'hA08, 64'hA08, 1'b0, 1'b0, 1'b1);
    chk_reset_state("mid_reset");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      idx = $urandom_range(0, 12);
      ins = (idx == 12) ? r : {r[31:7], ops[idx]};
      v = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 29) == 0);
      r = $urandom;
      cycle(v, ins, r, {$urandom, r}, ordy, fl, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
